data_memory_lat: RTL
====================

# data_memory_lat

Parametrised, multi-cycle line-wide data memory that sits behind the data cache as its backing store. It accepts one read and/or write request at a time, latches the request on acceptance, and completes it after a programmable latency with a one-cycle ready pulse. It generalises the fixed 256-bit / 512-entry / 10-cycle data memory in three ways: configurable width, depth and latency; byte-lane write masking; and a request latch, so requesters may change inputs once a request is accepted.

## Interface
Parameters:
- LINE_W, 256: line width in bits; must be a multiple of 8.
- ADDR_W, 27: line-address width.
- DEPTH, 512: number of lines; power of two, ≤ 2^ADDR_W.
- LATENCY, 10: cycles from acceptance to ready pulse; ≥ 1.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- DDATA_ren  in  1  read request.
- DDATA_wen  in  1  write request.
- DDATA_addr  in  ADDR_W  line address; index = addr[log2(DEPTH)-1:0], upper bits ignored.
- DDATA_wdata  in  LINE_W  write line.
- DDATA_wmask  in  LINE_W/8  byte-lane write enables; bit i covers wdata[8i+7:8i].
- DDATA_rdata  out  LINE_W  read line; valid only while ready=1 for a read, else 0.
- DDATA_ready  out  1  one-cycle completion pulse.
- DDATA_busy  out  1  a transaction is in flight (state BUSY).

## Operation
- States: IDLE, BUSY. Counter cnt, width ≥ clog2(LATENCY).
- Reset (rst_i=1 at an edge), with priority over everything:
  - state←IDLE, cnt←0, latched request cleared.
  - DDATA_ready=0, DDATA_busy=0, DDATA_rdata=0.
  - Memory array is not reset.
- IDLE, edge with ren|wen=1: accept the request.
  - Latch addr index, wdata, wmask, ren, wen.
  - state←BUSY, cnt←0.
- IDLE, ren=wen=0: hold.
- BUSY, cnt<LATENCY-1: cnt←cnt+1. Inputs are ignored; new requests are not queued.
- BUSY, cnt==LATENCY-1 (the ready cycle): DDATA_ready=1.
  - At the closing edge: state←IDLE, cnt←0.
  - If the latched wen=1, write each byte lane with mask bit 1 to mem[idx]; masked-off lanes keep their old value.
- Read data, combinational from the latched request:
  - During the ready cycle, if the latched ren=1: DDATA_rdata = merged line = mem[idx] with the latched masked wdata bytes overlaid if the latched wen=1, else mem[idx] unchanged.
  - Otherwise DDATA_rdata = 0.
- Simultaneous ren and wen: a single transaction. The write commits and the read returns the post-write line.
- wen with wmask=0: completes normally, memory unchanged.
- DDATA_busy = (state==BUSY).

## Timing
- Accept at edge E0. Ready is high for exactly the cycle between edges E0+LATENCY-1 and E0+LATENCY.
- LATENCY=1: ready in the first cycle after acceptance.
- Write is visible in the array from edge E0+LATENCY.
- Earliest next acceptance is edge E0+LATENCY+1 (one IDLE cycle between transactions). Throughput is one transaction per LATENCY+1 cycles.
- A request still asserted at the IDLE edge after ready is a new transaction. The requester must deassert on seeing ready.
- Reset mid-BUSY, including in the ready cycle:
  - Transaction abandoned, no write.
  - ready and busy go 0 from the next cycle.
- rst_i and a request at the same edge: reset wins, request is not accepted.

## Test plan
- Reset: hold rst_i 2 cycles with ren=1 -> ready=0, busy=0, rdata=0; no acceptance until after rst_i drops.
- Full write then read, LATENCY=10: write addr 5, wdata=all 0xA5, wmask=all 1s at E0. Expect ready only in the cycle E0+9→E0+10. Then read addr 5 at E0+11 -> ready in cycle E0+20→E0+21 with rdata all 0xA5, and rdata=0 in every other cycle.
- Byte mask: preload addr 3 with all 0x00. Write 0xFF..FF with wmask=0x0000_000F. Read back -> bytes 0–3 are 0xFF, the rest 0x00.
- Input latching and index wrap: accept a read of addr 7, then change addr/ren/wen every cycle while busy -> rdata=mem[7]; no extra transaction. Address DEPTH+7 reads the same line as 7.
- Combined rd+wr, LATENCY=1: ren=wen=1, addr 9, wmask=all 1s, wdata=0x1234.. -> ready in the first cycle with rdata=0x1234..; a subsequent read returns the same value.
- Reset mid-write: accept a write to addr 2, assert rst_i at cnt=4 -> no ready pulse; a later read of addr 2 returns the old contents.

Source files
------------

// File: rtl/data_memory_lat.sv
// data_memory_lat: line-wide backing store behind the data cache.
// One request is latched on acceptance and completes LATENCY cycles later
// with a single-cycle ready pulse. Writes honour per-byte lane enables.
//
// Handshake: a request (ren|wen) is accepted at any clock edge where the
// block is IDLE and reset is low. DDATA_busy is high from the cycle after
// acceptance until the ready cycle ends. DDATA_ready is high for exactly one
// cycle; DDATA_rdata is non-zero only in that cycle and only for reads.
// Inputs seen while busy are ignored and never queued.
module data_memory_lat #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 27,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  DDATA_ren,
  input  logic                  DDATA_wen,
  input  logic [ADDR_W-1:0]     DDATA_addr,
  input  logic [LINE_W-1:0]     DDATA_wdata,
  input  logic [LINE_W/8-1:0]   DDATA_wmask,
  output logic [LINE_W-1:0]     DDATA_rdata,
  output logic                  DDATA_ready,
  output logic                  DDATA_busy
);

  localparam int NB    = LINE_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]     wmask_q, wmask_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;

  logic [LINE_W-1:0] mem [DEPTH];
  logic [LINE_W-1:0] mem_line;
  logic [LINE_W-1:0] merged_line;
  logic              last_cycle;
  logic              mem_we;

  // Address bits above the index are deliberately ignored (index wraps).
  generate
    if (ADDR_W > IDX_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^DDATA_addr[ADDR_W-1:IDX_W];
    end
  endgenerate

  assign mem_line   = mem[idx_q];
  assign last_cycle = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);

  // Overlay the latched write bytes onto the stored line; this is both the
  // line committed at the closing edge and the line returned to a reader.
  always_comb begin
    merged_line = mem_line;
    for (int b = 0; b < NB; b++) begin
      if (wen_q && wmask_q[b]) begin
        merged_line[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  // Next-state logic: accept in IDLE, count in BUSY, commit on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (DDATA_ren || DDATA_wen) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          idx_d   = DDATA_addr[IDX_W-1:0];
          wdata_d = DDATA_wdata;
          wmask_d = DDATA_wmask;
          ren_d   = DDATA_ren;
          wen_d   = DDATA_wen;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          mem_we  = wen_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and request-latch registers; reset abandons any transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
    end
  end

  // Storage array (not reset); a reset edge suppresses the pending commit.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      mem[idx_q] <= merged_line;
    end
  end

  // Outputs decoded from the current state and latched request.
  always_comb begin
    DDATA_ready = last_cycle;
    DDATA_busy  = (state_q == ST_BUSY);
    DDATA_rdata = (last_cycle && ren_q) ? merged_line : '0;
  end

endmodule
